// File: rtl/lfsr_seq_checker_if.sv
// Sample stream in, lock/error status out, for the 12-bit LFSR sequence checker.
interface lfsr_seq_checker_if #(
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned SAMPLE_W = 12;

    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample;
    logic                clear_counts;
    logic                locked;
    logic                err_pulse;
    logic [CNT_W-1:0]    err_count;
    logic [CNT_W-1:0]    match_count;

    modport master (
        output sample_valid, sample, clear_counts,
        input  locked, err_pulse, err_count, match_count
    );

    modport slave (
        input  sample_valid, sample, clear_counts,
        output locked, err_pulse, err_count, match_count
    );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Synchronizes to a 12-bit LFSR stream (x^12+x^6+x^4+x+1), then counts
// matches and mismatches while locked, dropping lock after repeated misses.
module lfsr_seq_checker #(
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    lfsr_seq_checker_if.slave   bus
);
    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned CONF_W   = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W   = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_CONFIRM = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    function automatic logic [SAMPLE_W-1:0] lfsr_next(input logic [SAMPLE_W-1:0] s);
        return {s[10:0], s[11] ^ s[5] ^ s[3] ^ s[0]};
    endfunction

    state_t              r_state;
    state_t              w_next_state;
    logic [SAMPLE_W-1:0] r_pred;
    logic [CONF_W-1:0]   r_conf;
    logic [MISS_W-1:0]   r_miss;
    logic                r_locked;
    logic                r_err_pulse;
    logic [CNT_W-1:0]    r_err_count;
    logic [CNT_W-1:0]    r_match_count;

    logic [SAMPLE_W-1:0] w_pred_nxt;
    logic [CONF_W-1:0]   w_conf_nxt;
    logic [MISS_W-1:0]   w_miss_nxt;
    logic                w_err_pulse_nxt;
    logic                w_err_inc;
    logic                w_match_inc;

    logic                w_hit;
    logic                w_zero;
    logic [CONF_W-1:0]   w_conf_inc;
    logic [MISS_W-1:0]   w_miss_inc;

    assign w_hit      = (bus.sample == r_pred);
    assign w_zero     = (bus.sample == SAMPLE_W'(0));
    assign w_conf_inc = r_conf + CONF_W'(1);
    assign w_miss_inc = r_miss + MISS_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_HUNT;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (bus.sample_valid) begin
            case (r_state)
                S_HUNT: begin
                    if (!w_zero) w_next_state = S_CONFIRM;
                end
                S_CONFIRM: begin
                    if (w_hit) begin
                        if (w_conf_inc == CONF_W'(LOCK_COUNT)) w_next_state = S_LOCKED;
                    end else if (w_zero) begin
                        w_next_state = S_HUNT;
                    end
                end
                S_LOCKED: begin
                    if (!w_hit && (w_miss_inc == MISS_W'(UNLOCK_COUNT))) w_next_state = S_HUNT;
                end
                default: w_next_state = S_HUNT;
            endcase
        end
    end

    // Datapath next values; the predictor freewheels once locked
    always_comb begin
        w_pred_nxt      = r_pred;
        w_conf_nxt      = r_conf;
        w_miss_nxt      = r_miss;
        w_err_pulse_nxt = 1'b0;
        w_err_inc       = 1'b0;
        w_match_inc     = 1'b0;
        if (bus.sample_valid) begin
            case (r_state)
                S_HUNT: begin
                    if (!w_zero) begin
                        w_pred_nxt = lfsr_next(bus.sample);
                        w_conf_nxt = '0;
                    end
                end
                S_CONFIRM: begin
                    if (w_hit) begin
                        w_pred_nxt = lfsr_next(bus.sample);
                        w_conf_nxt = w_conf_inc;
                        if (w_conf_inc == CONF_W'(LOCK_COUNT)) w_miss_nxt = '0;
                    end else if (!w_zero) begin
                        w_pred_nxt = lfsr_next(bus.sample);
                        w_conf_nxt = '0;
                    end
                end
                S_LOCKED: begin
                    w_pred_nxt = lfsr_next(r_pred);
                    if (w_hit) begin
                        w_match_inc = 1'b1;
                        w_miss_nxt  = '0;
                    end else begin
                        w_err_pulse_nxt = 1'b1;
                        w_err_inc       = 1'b1;
                        w_miss_nxt      = w_miss_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers; clear_counts beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pred        <= '0;
            r_conf        <= '0;
            r_miss        <= '0;
            r_locked      <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_err_count   <= '0;
            r_match_count <= '0;
        end else begin
            r_pred      <= w_pred_nxt;
            r_conf      <= w_conf_nxt;
            r_miss      <= w_miss_nxt;
            r_locked    <= (w_next_state == S_LOCKED);
            r_err_pulse <= w_err_pulse_nxt;
            if (bus.clear_counts) begin
                r_err_count   <= '0;
                r_match_count <= '0;
            end else begin
                if (w_err_inc && (r_err_count != '1))
                    r_err_count <= r_err_count + CNT_W'(1);
                if (w_match_inc && (r_match_count != '1))
                    r_match_count <= r_match_count + CNT_W'(1);
            end
        end
    end

    assign bus.locked      = r_locked;
    assign bus.err_pulse   = r_err_pulse;
    assign bus.err_count   = r_err_count;
    assign bus.match_count = r_match_count;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: reference model feeds a scoreboard queue,
// outputs are popped and compared one cycle after each driven sample.
module tb_lfsr_seq_checker;
    localparam int unsigned LOCK_N   = 4;
    localparam int unsigned UNLOCK_N = 3;
    localparam int unsigned CW       = 4;

    typedef struct {
        logic          locked;
        logic          err_pulse;
        logic [CW-1:0] err_count;
        logic [CW-1:0] match_count;
    } exp_t;

    logic clk;
    logic reset;
    lfsr_seq_checker_if #(.CNT_W(CW)) bus ();

    lfsr_seq_checker #(
        .LOCK_COUNT  (LOCK_N),
        .UNLOCK_COUNT(UNLOCK_N),
        .CNT_W       (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    // Reference model state
    int          m_state;   // 0 hunt, 1 confirm, 2 locked
    logic [11:0] m_pred;
    int          m_conf;
    int          m_miss;
    logic        m_errp;
    int          m_ec;
    int          m_mc;
    logic [11:0] gen;

    function automatic logic [11:0] nx(input logic [11:0] s);
        logic [11:0] taps;
        taps = 12'h829;
        return (s << 1) | 12'(^(s & taps));
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic v, input logic [11:0] s, input logic clr, input logic rst);
        if (rst) begin
            m_state = 0; m_pred = '0; m_conf = 0; m_miss = 0;
            m_errp = 0; m_ec = 0; m_mc = 0;
            return;
        end
        m_errp = 0;
        if (v) begin
            if (m_state == 0) begin
                if (s != 0) begin m_pred = nx(s); m_conf = 0; m_state = 1; end
            end else if (m_state == 1) begin
                if (s == m_pred) begin
                    m_conf++;
                    m_pred = nx(s);
                    if (m_conf == LOCK_N) begin m_state = 2; m_miss = 0; end
                end else if (s != 0) begin
                    m_pred = nx(s); m_conf = 0;
                end else begin
                    m_state = 0;
                end
            end else begin
                if (s == m_pred) begin
                    if (m_mc < (1 << CW) - 1) m_mc++;
                    m_miss = 0;
                end else begin
                    m_errp = 1;
                    if (m_ec < (1 << CW) - 1) m_ec++;
                    m_miss++;
                    if (m_miss == UNLOCK_N) m_state = 0;
                end
                m_pred = nx(m_pred);
            end
        end
        if (clr) begin m_ec = 0; m_mc = 0; end
    endtask

    task automatic step(input logic v, input logic [11:0] s, input logic clr, input logic rst);
        exp_t e;
        @(negedge clk);
        bus.sample_valid = v;
        bus.sample       = s;
        bus.clear_counts = clr;
        reset            = rst;
        model(v, s, clr, rst);
        e.locked      = (m_state == 2);
        e.err_pulse   = m_errp;
        e.err_count   = CW'(m_ec);
        e.match_count = CW'(m_mc);
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk("sb_depth", 16'(sb.size()), 16'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("locked",      16'(bus.locked),      16'(e.locked));
            chk("err_pulse",   16'(bus.err_pulse),   16'(e.err_pulse));
            chk("err_count",   16'(bus.err_count),   16'(e.err_count));
            chk("match_count", 16'(bus.match_count), 16'(e.match_count));
        end
    endtask

    task automatic good();
        step(1'b1, gen, 1'b0, 1'b0);
        gen = nx(gen);
    endtask

    task automatic bad(input logic clr);
        step(1'b1, gen ^ 12'h555, clr, 1'b0);
        gen = nx(gen);
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        bus.clear_counts = 1'b0;
        reset            = 1'b1;
        model(1'b0, '0, 1'b0, 1'b1);

        // Reset with valid/clear asserted: reset wins
        step(1'b1, 12'h001, 1'b1, 1'b1);
        step(1'b1, 12'h003, 1'b0, 1'b1);
        chk("reset_locked", 16'(bus.locked), 16'd0);
        chk("reset_err",    16'(bus.err_count), 16'd0);

        // Zeros ignored in hunt, then lock on the 5th correct sample
        step(1'b1, 12'h000, 1'b0, 1'b0);
        step(1'b1, 12'h000, 1'b0, 1'b0);
        gen = 12'h001;
        for (int i = 0; i < 4; i++) good();
        chk("no_lock_after_4", 16'(bus.locked), 16'd0);
        chk("gen_5th_is_01E", 16'(gen), 16'h01E);
        good();
        chk("lock_after_5", 16'(bus.locked), 16'd1);
        chk("lock_err0",    16'(bus.err_count), 16'd0);

        // Idle cycles change nothing
        for (int i = 0; i < 3; i++) step(1'b0, 12'hFFF, 1'b0, 1'b0);
        good(); good();
        chk("match_2", 16'(bus.match_count), 16'd2);

        // Single replaced sample
        step(1'b1, 12'hABC, 1'b0, 1'b0);
        gen = nx(gen);
        chk("abc_pulse",  16'(bus.err_pulse), 16'd1);
        chk("abc_errcnt", 16'(bus.err_count), 16'd1);
        chk("abc_locked", 16'(bus.locked),    16'd1);
        good();
        chk("abc_pulse_gone", 16'(bus.err_pulse), 16'd0);
        chk("abc_next_match", 16'(bus.match_count), 16'd3);

        // Clear in the same cycle as a mismatch
        bad(1'b1);
        chk("clr_pulse",  16'(bus.err_pulse), 16'd1);
        chk("clr_errcnt", 16'(bus.err_count), 16'd0);
        chk("clr_locked", 16'(bus.locked),    16'd1);
        good();

        // Three consecutive misses drop lock, five good samples relock
        bad(1'b0); bad(1'b0);
        chk("miss2_locked", 16'(bus.locked), 16'd1);
        bad(1'b0);
        chk("miss3_pulse",  16'(bus.err_pulse), 16'd1);
        chk("miss3_locked", 16'(bus.locked),    16'd0);
        chk("miss3_errcnt", 16'(bus.err_count), 16'd3);
        for (int i = 0; i < 4; i++) good();
        chk("relock_not_yet", 16'(bus.locked), 16'd0);
        good();
        chk("relock", 16'(bus.locked), 16'd1);

        // Confirm-phase reseed and zero-return to hunt
        for (int i = 0; i < UNLOCK_N; i++) bad(1'b0);
        good(); good();
        gen = 12'h7A3;
        good();            // mismatch in confirm: reseeds from 7A3
        for (int i = 0; i < 3; i++) good();
        chk("reseed_not_yet", 16'(bus.locked), 16'd0);
        step(1'b1, 12'h000, 1'b0, 1'b0);   // zero in confirm: back to hunt
        for (int i = 0; i < 4; i++) good();
        chk("zero_hunt_not_yet", 16'(bus.locked), 16'd0);
        good();
        chk("zero_hunt_relock", 16'(bus.locked), 16'd1);

        // Saturation of both counters
        for (int i = 0; i < 20; i++) good();
        chk("match_sat", 16'(bus.match_count), 16'hF);
        for (int i = 0; i < 20; i++) begin bad(1'b0); good(); end
        chk("err_sat", 16'(bus.err_count), 16'hF);
        chk("sat_locked", 16'(bus.locked), 16'd1);
        step(1'b0, 12'h000, 1'b1, 1'b0);
        chk("clr_idle_match", 16'(bus.match_count), 16'd0);

        // Reset mid-lock, then relock takes LOCK_COUNT+1 samples
        good();
        step(1'b1, gen, 1'b0, 1'b1);
        step(1'b1, gen, 1'b0, 1'b1);
        chk("midrst_locked", 16'(bus.locked),      16'd0);
        chk("midrst_match",  16'(bus.match_count), 16'd0);
        for (int i = 0; i < 4; i++) good();
        chk("midrst_not_yet", 16'(bus.locked), 16'd0);
        good();
        chk("midrst_relock", 16'(bus.locked), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_checker.md
LFSR_SEQ_CHECKER -- requirements
Module: lfsr_seq_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 4: consecutive correct predictions required before lock is declared.
REQ-002 Parameter UNLOCK_COUNT, default 3: consecutive mismatches while locked that drop lock.
REQ-003 Parameter CNT_W, default 16: width of the error and match counters.
REQ-004 Port clk  input  1  single clock; all logic is on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port sample_valid  input  1  sample is valid this cycle.
REQ-007 Port sample  input  12  value from the 12-bit LFSR random generator.
REQ-008 Port clear_counts  input  1  synchronous clear of err_count and match_count.
REQ-009 Port locked  output  1  checker is synchronized to the sequence.
REQ-010 Port err_pulse  output  1  one-cycle flag for a mismatched sample while locked.
REQ-011 Port err_count  output  CNT_W  saturating count of mismatches while locked.
REQ-012 Port match_count  output  CNT_W  saturating count of matches while locked.

Function
REQ-013 Next-state function N(s): fb = s[11]^s[5]^s[3]^s[0]; N(s) = {s[10:0], fb}, matching the generator polynomial x^12+x^6+x^4+x+1.
REQ-014 Sample 12'h000 is illegal (lock-up state) and is never treated as a valid seed.
REQ-015 Cycles with sample_valid=0 change no state, no prediction and no counters.
REQ-016 States: HUNT, CONFIRM, LOCKED; a 12-bit predictor register pred; a confirm counter; a miss counter.
REQ-017 HUNT: a valid nonzero sample sets pred=N(sample), sets confirm=0 and moves to CONFIRM; a valid zero sample leaves the state in HUNT.
REQ-018 CONFIRM, valid sample==pred: confirm increments and pred=N(sample); when the incremented confirm equals LOCK_COUNT, move to LOCKED and set miss=0.
REQ-019 CONFIRM, valid sample!=pred: if sample is nonzero, reseed pred=N(sample), set confirm=0 and stay in CONFIRM; if sample is zero, go to HUNT.
REQ-020 LOCKED, valid sample==pred: increment match_count (saturating), set miss=0.
REQ-021 LOCKED, valid sample!=pred: assert err_pulse, increment err_count (saturating), increment miss; the predictor freewheels; no reseed from a bad sample.
REQ-022 In LOCKED, pred=N(pred) on every valid sample, match or mismatch.
REQ-023 When the incremented miss equals UNLOCK_COUNT, move to HUNT; locked deasserts in the same cycle err_pulse fires for that sample.
REQ-024 locked=1 exactly when the state is LOCKED; every output is registered, giving one-cycle latency from the deciding sample edge to the output.
REQ-025 err_pulse is high for exactly one cycle per mismatched valid sample in LOCKED; it is never asserted in HUNT or CONFIRM.
REQ-026 Counters hold at 2^CNT_W-1 and do not wrap.
REQ-027 clear_counts zeros both counters on the next edge and takes priority over a simultaneous increment; err_pulse still fires; state, pred and miss are unaffected.

Reset
REQ-028 While reset=1 at a clock edge: state=HUNT, pred=0, confirm=0, miss=0, locked=0, err_pulse=0, err_count=0, match_count=0.
REQ-029 reset overrides sample_valid and clear_counts in the same cycle.
REQ-030 reset during LOCKED or CONFIRM discards lock; after release, resynchronization restarts from HUNT.

Verification
REQ-031 Stream 001,003,007,00F,01E,... at LOCK_COUNT=4 -> locked rises one cycle after the 5th sample (01E), with err_count=0.
REQ-032 After lock, replace one sample with 12'hABC and continue the correct sequence -> one err_pulse, err_count=1, locked stays 1, and the next correct sample is counted in match_count.
REQ-033 After lock, corrupt 3 consecutive samples -> 3 err_pulses; locked falls with the 3rd; the checker relocks after 5 further correct samples.
REQ-034 Samples 000,000,001,003,... -> zeros are ignored in HUNT, and lock is reached as in REQ-031.
REQ-035 Locked, reset=1 for 2 cycles mid-stream -> all outputs are 0, and relock takes LOCK_COUNT+1 valid samples.
REQ-036 Locked, assert clear_counts in the same cycle as a mismatched sample -> err_pulse=1, err_count=0 next cycle, locked stays 1.
